cpu_de_stage: RTL
=================

# cpu_de_stage

Decode-to-execute pipeline register of the MCS8 pipelined core. Latches the decoded instruction (opcode, source/destination register index, destination-class flags) into the E stage. It inserts a bubble when the data-hazard unit requests one, holds on execute stall, and discards wrong-path instructions after a flush. Its E-side outputs feed the data-hazard unit's E-stage inputs and the execute stage.

## Interface
- FLUSH_DEPTH, default 1: number of decode slots discarded after FLUSH_I (1..7).
- CNT_W, default 16: width of the bubble counter.
- CLK_I  in  1  clock; all state changes on rising edge.
- RST_N_I  in  1  reset; asynchronous assert, active-low.
- D_VALID_I  in  1  decode slot holds a valid instruction.
- D_OP_I  in  8  decoded opcode.
- D_SRC_I  in  3  source register index.
- D_DST_I  in  3  destination register index.
- D_DSTR_CS_C_I / _S_I / _E_I / _M_I  in  1 each  destination-class flags.
- BUBBLE_DATA_I  in  1  data-hazard bubble request.
- E_STALL_I  in  1  execute stage cannot accept; hold E register.
- FLUSH_I  in  1  control-flow redirect; kill E and wrong-path slots.
- E_VALID_O  out  1  E register holds a live instruction.
- E_OP_O  out  8  latched opcode.
- E_SRC_O  out  3  latched source register index.
- E_DST_O  out  3  latched destination register index.
- E_DSTR_CS_C_O / _S_O / _E_O / _M_O  out  1 each  latched destination-class flags.
- D_STALL_O  out  1  decode/fetch must hold current slot (combinational).
- BUBBLE_CNT_O  out  CNT_W  bubbles inserted since reset.

## Operation
- FSM states: ST_RUN, ST_BUBBLE, ST_SHADOW.
- Per-cycle priority: reset > FLUSH_I > E_STALL_I > BUBBLE_DATA_I > normal load.
- Reset: every output register is 0, so E_VALID_O=0 and all E_* fields are 0. BUBBLE_CNT_O=0, FSM=ST_RUN, shadow counter=0.
- FLUSH_I=1:
  - E_VALID_O<=0.
  - Shadow counter<=FLUSH_DEPTH; FSM enters ST_SHADOW.
  - Overrides a stall or bubble in the same cycle.
- ST_SHADOW:
  - Each cycle with D_VALID_I=1 is consumed and discarded. E_VALID_O<=0 and the counter decrements.
  - Cycles with D_VALID_I=0 do not decrement.
  - Counter reaching 0 returns the FSM to ST_RUN.
  - BUBBLE_DATA_I is ignored here, because a wrong-path instruction must not stall.
- E_STALL_I=1 (no flush): all E registers hold their value; D_STALL_O=1.
- BUBBLE_DATA_I=1 with D_VALID_I=1 (no flush, no stall):
  - E_VALID_O<=0 and E_* fields hold; D_STALL_O=1.
  - FSM=ST_BUBBLE; the counter increments, saturating at all-ones.
  - The decode slot is re-presented on the next cycle.
- Normal load: E_* <= D_* and E_VALID_O<=D_VALID_I; FSM=ST_RUN.
- D_STALL_O = ~FLUSH_I & (E_STALL_I | (BUBBLE_DATA_I & D_VALID_I & ~ST_SHADOW)).

## Timing
- Latency: D_* to E_* is 1 cycle.
- A bubble costs 1 cycle per asserted BUBBLE_DATA_I. Back-to-back bubbles produce consecutive E_VALID_O=0 cycles.
- FLUSH_I takes effect at the next edge. The first post-flush instruction can load FLUSH_DEPTH valid slots later.
- Async reset mid-operation clears state immediately, without waiting for a clock edge. Deassertion is taken at the next edge.

## Configuration
- CPU_DE_BUBBLE_CNT_EN defined: the CNT_W-bit saturating bubble counter is built and drives BUBBLE_CNT_O. The count increments only on cycles that actually insert a bubble.
- Not defined: no counter logic is built; BUBBLE_CNT_O is tied to 0 and the port remains present.

## Structure
- Shared header cpu_pipe_defs.vh contains:
  - FSM state encodings (ST_RUN=2'd0, ST_BUBBLE=2'd1, ST_SHADOW=2'd2).
  - Register-index width (3) and opcode width (8), shared with the hazard unit and execute stage.
- One sub-module, cpu_sat_cnt: parameterised saturating up-counter with async active-low reset, instantiated under CPU_DE_BUBBLE_CNT_EN.

## Test plan
- Reset with D_VALID_I=1, D_DST_I=3'd5 → all outputs 0 while RST_N_I=0. First edge after release loads E_DST_O=5 and E_VALID_O=1.
- D_OP_I=8'hC1, D_VALID_I=1, BUBBLE_DATA_I=1 for 2 cycles then 0 → E_VALID_O=0 for 2 cycles; D_STALL_O=1 both cycles; then E_OP_O=C1 with E_VALID_O=1; BUBBLE_CNT_O=2.
- E_STALL_I=1 and BUBBLE_DATA_I=1 together with E_OP_O=8'h44 live → E_OP_O holds 44, E_VALID_O stays 1, BUBBLE_CNT_O unchanged.
- FLUSH_I=1 for one cycle with FLUSH_DEPTH=2 and E_STALL_I=1 → D_STALL_O=0, E_VALID_O=0 next cycle. Of the following D_VALID_I pattern 1,0,1,1, the first two valid slots are dropped and the third loads.
- Bubble counter at 16'hFFFF plus one more bubble → stays 16'hFFFF. Without the macro, BUBBLE_CNT_O=0 throughout.
- RST_N_I pulsed low mid-cycle during ST_SHADOW → outputs clear asynchronously. After release the next valid slot loads, with no residual shadow discard.

Source files
------------

// File: rtl/cpu_de_stage_pkg.sv
// -----------------------------------------------------------------------------
// cpu_de_stage_pkg
// Shared definitions for the MCS8 decode-to-execute boundary: FSM state
// encodings, register-index and opcode widths (common with the hazard unit
// and execute stage), and the decoded-instruction payload carried into E.
// -----------------------------------------------------------------------------
package cpu_de_stage_pkg;

   localparam int unsigned OP_W  = 8;   // opcode width
   localparam int unsigned REG_W = 3;   // register-index width
   localparam int unsigned SHD_W = 3;   // shadow (post-flush discard) counter width

   typedef enum logic [1:0] {
      ST_RUN    = 2'd0,
      ST_BUBBLE = 2'd1,
      ST_SHADOW = 2'd2
   } de_state_t;

   // Decoded instruction fields latched from D into E.
   typedef struct packed {
      logic [OP_W-1:0]  op;
      logic [REG_W-1:0] src;
      logic [REG_W-1:0] dst;
      logic             cs_c;
      logic             cs_s;
      logic             cs_e;
      logic             cs_m;
   } de_payload_t;

endpackage

// File: rtl/cpu_sat_cnt.sv
// -----------------------------------------------------------------------------
// cpu_sat_cnt
// Parameterised saturating up-counter; holds at all-ones once reached.
// Ports:
//   clk_i   - clock
//   rst_ni  - asynchronous active-low reset (count clears to 0)
//   inc_i   - increment request for this cycle
//   cnt_o   - registered count value (W bits)
// -----------------------------------------------------------------------------
module cpu_sat_cnt #(
   parameter int unsigned W = 16
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q;
   logic [W-1:0] cnt_d;

   // Next count: increment unless already saturated.
   always_comb begin
      cnt_d = cnt_q;
      if (inc_i && (cnt_q != {W{1'b1}})) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   // Count register.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/cpu_de_stage.sv
// -----------------------------------------------------------------------------
// cpu_de_stage
// Decode-to-execute pipeline register of the MCS8 pipelined core. Latches the
// decoded instruction into E, inserts a bubble on a data-hazard request, holds
// on execute stall, and discards FLUSH_DEPTH wrong-path decode slots after a
// control-flow flush.
//
// Optional feature macro: CPU_DE_BUBBLE_CNT_EN
//   defined   - saturating CNT_W-bit bubble counter drives BUBBLE_CNT_O
//   undefined - no counter logic, BUBBLE_CNT_O tied to 0
//
// Ports:
//   CLK_I, RST_N_I              - clock, async active-low reset
//   D_VALID_I, D_OP_I, D_SRC_I,
//   D_DST_I, D_DSTR_CS_*_I      - decode slot contents
//   BUBBLE_DATA_I               - data-hazard bubble request
//   E_STALL_I                   - execute stage cannot accept; hold E
//   FLUSH_I                     - control-flow redirect
//   E_VALID_O, E_OP_O, E_SRC_O,
//   E_DST_O, E_DSTR_CS_*_O      - registered E-stage instruction
//   D_STALL_O                   - combinational hold request to decode/fetch
//   BUBBLE_CNT_O                - bubbles inserted since reset
// -----------------------------------------------------------------------------
module cpu_de_stage
   import cpu_de_stage_pkg::*;
#(
   parameter int unsigned FLUSH_DEPTH = 1,
   parameter int unsigned CNT_W       = 16
) (
   input  logic             CLK_I,
   input  logic             RST_N_I,
   input  logic             D_VALID_I,
   input  logic [OP_W-1:0]  D_OP_I,
   input  logic [REG_W-1:0] D_SRC_I,
   input  logic [REG_W-1:0] D_DST_I,
   input  logic             D_DSTR_CS_C_I,
   input  logic             D_DSTR_CS_S_I,
   input  logic             D_DSTR_CS_E_I,
   input  logic             D_DSTR_CS_M_I,
   input  logic             BUBBLE_DATA_I,
   input  logic             E_STALL_I,
   input  logic             FLUSH_I,
   output logic             E_VALID_O,
   output logic [OP_W-1:0]  E_OP_O,
   output logic [REG_W-1:0] E_SRC_O,
   output logic [REG_W-1:0] E_DST_O,
   output logic             E_DSTR_CS_C_O,
   output logic             E_DSTR_CS_S_O,
   output logic             E_DSTR_CS_E_O,
   output logic             E_DSTR_CS_M_O,
   output logic             D_STALL_O,
   output logic [CNT_W-1:0] BUBBLE_CNT_O
);

   de_state_t            state_q, state_d;
   logic [SHD_W-1:0]     shd_cnt_q, shd_cnt_d;
   logic                 e_valid_q, e_valid_d;
   de_payload_t          e_pay_q, e_pay_d;
   de_payload_t          d_pay_c;
   logic                 bubble_req_c;

   // Gather the decode slot into one payload.
   always_comb begin
      d_pay_c.op   = D_OP_I;
      d_pay_c.src  = D_SRC_I;
      d_pay_c.dst  = D_DST_I;
      d_pay_c.cs_c = D_DSTR_CS_C_I;
      d_pay_c.cs_s = D_DSTR_CS_S_I;
      d_pay_c.cs_e = D_DSTR_CS_E_I;
      d_pay_c.cs_m = D_DSTR_CS_M_I;
   end

   // Wrong-path slots in the shadow must never stall the front end.
   assign bubble_req_c = BUBBLE_DATA_I & D_VALID_I & (state_q != ST_SHADOW);
   assign D_STALL_O    = ~FLUSH_I & (E_STALL_I | bubble_req_c);

   // Next-state: flush > stall > shadow discard > bubble > normal load.
   always_comb begin
      state_d   = state_q;
      shd_cnt_d = shd_cnt_q;
      e_valid_d = e_valid_q;
      e_pay_d   = e_pay_q;

      if (FLUSH_I) begin
         e_valid_d = 1'b0;
         shd_cnt_d = SHD_W'(FLUSH_DEPTH);
         state_d   = ST_SHADOW;
      end else if (E_STALL_I) begin
         // Hold everything; decode keeps its slot, so nothing is consumed.
      end else if (state_q == ST_SHADOW) begin
         e_valid_d = 1'b0;
         if (D_VALID_I) begin
            if (shd_cnt_q <= SHD_W'(1)) begin
               shd_cnt_d = '0;
               state_d   = ST_RUN;
            end else begin
               shd_cnt_d = shd_cnt_q - SHD_W'(1);
            end
         end
      end else if (bubble_req_c) begin
         // Fields hold; the same decode slot is re-presented next cycle.
         e_valid_d = 1'b0;
         state_d   = ST_BUBBLE;
      end else begin
         e_valid_d = D_VALID_I;
         e_pay_d   = d_pay_c;
         state_d   = ST_RUN;
      end
   end

   // State and E register.
   always_ff @(posedge CLK_I or negedge RST_N_I) begin
      if (!RST_N_I) begin
         state_q   <= ST_RUN;
         shd_cnt_q <= '0;
         e_valid_q <= 1'b0;
         e_pay_q   <= '0;
      end else begin
         state_q   <= state_d;
         shd_cnt_q <= shd_cnt_d;
         e_valid_q <= e_valid_d;
         e_pay_q   <= e_pay_d;
      end
   end

   assign E_VALID_O     = e_valid_q;
   assign E_OP_O        = e_pay_q.op;
   assign E_SRC_O       = e_pay_q.src;
   assign E_DST_O       = e_pay_q.dst;
   assign E_DSTR_CS_C_O = e_pay_q.cs_c;
   assign E_DSTR_CS_S_O = e_pay_q.cs_s;
   assign E_DSTR_CS_E_O = e_pay_q.cs_e;
   assign E_DSTR_CS_M_O = e_pay_q.cs_m;

`ifdef CPU_DE_BUBBLE_CNT_EN
   // Count only cycles that actually insert a bubble into E.
   logic bubble_ins_c;
   assign bubble_ins_c = bubble_req_c & ~FLUSH_I & ~E_STALL_I;

   cpu_sat_cnt #(
      .W (CNT_W)
   ) u_bubble_cnt (
      .clk_i  (CLK_I),
      .rst_ni (RST_N_I),
      .inc_i  (bubble_ins_c),
      .cnt_o  (BUBBLE_CNT_O)
   );
`else
   assign BUBBLE_CNT_O = '0;
`endif

endmodule
